fluorescence_measurement_sequencer: RTL and testbench

// - Runs the photon-counting core (lock-in add/subtract counter, modulated light source) through one measurement run.
// - A run is: latch config, program the core, settle, then N integration windows.
// - Emits per-window net counts on a valid/ready stream and a saturating run total.
// - Sits between the host/config logic and the counting core; it is the core's only master.

---
 rtl/fluor_pkg.sv | 17 +
 rtl/fluor_sat_accum.sv | 50 +++++
 rtl/fluorescence_measurement_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_fluorescence_measurement_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fluor_pkg.sv
// rtl/fluor_pkg.sv - shared types and defaults for the fluorescence measurement sequencer
package fluor_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_IDX_W = 16;
  localparam int DEF_TOT_W = 48;
  localparam int MIN_TIME  = 2;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    SETTLE,
    INTEGRATE,
    REPORT
  } state_e;

endpackage

// File: rtl/fluor_sat_accum.sv
// rtl/fluor_sat_accum.sv - saturating run-total accumulator with clear and sticky saturation flag
module fluor_sat_accum
  import fluor_pkg::*;
#(
  parameter int TOT_W = DEF_TOT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             add_en,
  input  logic [TOT_W-1:0] add_val,
  output logic [TOT_W-1:0] total,
  output logic             sat
);

  logic [TOT_W-1:0] total_q, total_d;
  logic             sat_q, sat_d;
  logic [TOT_W:0]   sum;

  always_comb begin
    sum     = {1'b0, total_q} + {1'b0, add_val};
    total_d = total_q;
    sat_d   = sat_q;
    if (clear) begin
      total_d = '0;
      sat_d   = 1'b0;
    end else if (add_en) begin
      if (sum[TOT_W]) begin
        total_d = '1;
        sat_d   = 1'b1;
      end else begin
        total_d = sum[TOT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      total_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      total_q <= total_d;
      sat_q   <= sat_d;
    end
  end

  assign total = total_q;
  assign sat   = sat_q;

endmodule

// File: rtl/fluorescence_measurement_sequencer.sv
// rtl/fluorescence_measurement_sequencer.sv - drives the photon-counting core through one measurement run
// Define FLUOR_SEQ_TIMEOUT_EN to add an INTEGRATE watchdog (integration time + TMO_MARGIN clocks).
module fluorescence_measurement_sequencer
  import fluor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int TOT_W = DEF_TOT_W
`ifdef FLUOR_SEQ_TIMEOUT_EN
  ,
  parameter int TMO_MARGIN = 1024
`endif
) (
  input  logic             clock_50_mhz,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] cfg_num_windows,
  input  logic [CNT_W-1:0] cfg_integration_time,
  input  logic [CNT_W-1:0] cfg_modulation_period,
  input  logic [IDX_W-1:0] cfg_settle_cycles,
  output logic [CNT_W-1:0] core_integration_time,
  output logic [CNT_W-1:0] core_modulation_period,
  output logic             core_light_en,
  output logic             core_count_en,
  output logic             core_clear,
  input  logic             core_window_done,
  input  logic [CNT_W-1:0] core_add_count,
  input  logic [CNT_W-1:0] core_sub_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_data,
  output logic [IDX_W-1:0] res_index,
  output logic             res_last,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [TOT_W-1:0] total_count,
  output logic             total_sat
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] num_win_q, num_win_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  logic [IDX_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0] int_time_q, int_time_d;
  logic [CNT_W-1:0] mod_period_q, mod_period_d;
  logic [CNT_W-1:0] res_data_q, res_data_d;
  logic [IDX_W-1:0] res_index_q, res_index_d;
  logic             res_valid_q, res_valid_d;
  logic             res_last_q, res_last_d;
  logic             light_q, light_d;
  logic             count_q, count_d;
  logic             clear_q, clear_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             acc_clear, acc_add;
  logic             kill;

`ifdef FLUOR_SEQ_TIMEOUT_EN
  logic [CNT_W:0] wd_q, wd_d;
  logic [CNT_W:0] wd_limit;

  // wd_q is 0 on the first INTEGRATE cycle, so the abort lands exactly limit clocks after entry
  assign wd_limit = {1'b0, int_time_q} + (CNT_W+1)'(TMO_MARGIN) - 1'b1;
  assign wd_d     = (state_q == INTEGRATE) ? wd_q + 1'b1 : '0;
  assign kill     = abort || ((state_q == INTEGRATE) && (wd_q == wd_limit));

  always_ff @(posedge clock_50_mhz) begin
    if (!reset_n) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`else
  assign kill = abort;
`endif

  always_comb begin
    state_d      = state_q;
    num_win_d    = num_win_q;
    win_idx_d    = win_idx_q;
    settle_cnt_d = settle_cnt_q;
    int_time_d   = int_time_q;
    mod_period_d = mod_period_q;
    res_data_d   = res_data_q;
    res_index_d  = res_index_q;
    res_valid_d  = res_valid_q;
    res_last_d   = res_last_q;
    light_d      = light_q;
    count_d      = count_q;
    clear_d      = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    acc_clear    = 1'b0;
    acc_add      = 1'b0;

    // abort outranks window_done and the result handshake in every active state
    if (state_q != IDLE && kill) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
      light_d     = 1'b0;
      count_d     = 1'b0;
      aborted_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            num_win_d    = cfg_num_windows;
            settle_cnt_d = cfg_settle_cycles;
            win_idx_d    = '0;
            int_time_d   = (cfg_integration_time < CNT_W'(MIN_TIME)) ? CNT_W'(MIN_TIME) : cfg_integration_time;
            mod_period_d = (cfg_modulation_period < CNT_W'(MIN_TIME)) ? CNT_W'(MIN_TIME) : cfg_modulation_period;
            acc_clear    = 1'b1;
            if (cfg_num_windows == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = CONFIG;
              clear_d = 1'b1;
              light_d = 1'b1;
            end
          end
        end
        CONFIG: begin
          if (settle_cnt_q == '0) begin
            state_d = INTEGRATE;
            clear_d = 1'b1;
            count_d = 1'b1;
          end else begin
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt_q <= IDX_W'(1)) begin
            state_d = INTEGRATE;
            clear_d = 1'b1;
            count_d = 1'b1;
          end else begin
            settle_cnt_d = settle_cnt_q - 1'b1;
          end
        end
        INTEGRATE: begin
          if (core_window_done) begin
            res_data_d  = (core_add_count >= core_sub_count) ? core_add_count - core_sub_count : '0;
            res_index_d = win_idx_q;
            res_last_d  = (win_idx_q == num_win_q - 1'b1);
            res_valid_d = 1'b1;
            count_d     = 1'b0;
            state_d     = REPORT;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            acc_add     = 1'b1;
            if (res_last_q) begin
              light_d = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              win_idx_d = win_idx_q + 1'b1;
              clear_d   = 1'b1;
              count_d   = 1'b1;
              state_d   = INTEGRATE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_50_mhz) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      num_win_q    <= '0;
      win_idx_q    <= '0;
      settle_cnt_q <= '0;
      int_time_q   <= CNT_W'(MIN_TIME);
      mod_period_q <= CNT_W'(MIN_TIME);
      res_data_q   <= '0;
      res_index_q  <= '0;
      res_valid_q  <= 1'b0;
      res_last_q   <= 1'b0;
      light_q      <= 1'b0;
      count_q      <= 1'b0;
      clear_q      <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_win_q    <= num_win_d;
      win_idx_q    <= win_idx_d;
      settle_cnt_q <= settle_cnt_d;
      int_time_q   <= int_time_d;
      mod_period_q <= mod_period_d;
      res_data_q   <= res_data_d;
      res_index_q  <= res_index_d;
      res_valid_q  <= res_valid_d;
      res_last_q   <= res_last_d;
      light_q      <= light_d;
      count_q      <= count_d;
      clear_q      <= clear_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  fluor_sat_accum #(
    .TOT_W (TOT_W)
  ) u_accum (
    .clk     (clock_50_mhz),
    .resetn  (reset_n),
    .clear   (acc_clear),
    .add_en  (acc_add),
    .add_val ({{(TOT_W-CNT_W){1'b0}}, res_data_q}),
    .total   (total_count),
    .sat     (total_sat)
  );

  assign core_integration_time  = int_time_q;
  assign core_modulation_period = mod_period_q;
  assign core_light_en          = light_q;
  assign core_count_en          = count_q;
  assign core_clear             = clear_q;
  assign res_valid              = res_valid_q;
  assign res_data               = res_data_q;
  assign res_index              = res_index_q;
  assign res_last               = res_last_q;
  assign busy                   = (state_q != IDLE);
  assign done                   = done_q;
  assign aborted                = aborted_q;

endmodule

// File: tb/tb_fluorescence_measurement_sequencer.sv
// tb/tb_fluorescence_measurement_sequencer.sv - scoreboard bench with randomized core emulation
// Build with FLUOR_SEQ_TIMEOUT_EN to exercise the watchdog instead of the no-watchdog wait.
module tb_fluorescence_measurement_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, start, abort;
  logic [15:0] cfg_num_windows, cfg_settle_cycles;
  logic [31:0] cfg_integration_time, cfg_modulation_period;
  logic [31:0] core_integration_time, core_modulation_period;
  logic        core_light_en, core_count_en, core_clear, core_window_done;
  logic [31:0] core_add_count, core_sub_count;
  logic        res_valid, res_ready, res_last;
  logic [31:0] res_data;
  logic [15:0] res_index;
  logic        busy, done, aborted, total_sat;
  logic [47:0] total_count;

  logic        acc_clear, acc_add_en, acc_sat;
  logic [47:0] acc_val, acc_total;

  typedef struct {
    logic [31:0] data;
    logic [15:0] idx;
    logic        last;
  } res_t;

  res_t        exp_q[$];
  res_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0, abort_cnt = 0, stall_cnt = 0;
  int          rdy_mode = 0;
  int          hold_cnt = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_data;
  logic [15:0] prev_idx;
  logic        prev_last;
  logic [31:0] dir_add [0:2] = '{32'd50, 32'd10, 32'd7};
  logic [31:0] dir_sub [0:2] = '{32'd20, 32'd30, 32'd0};

  always #10 clk = ~clk;

  fluorescence_measurement_sequencer dut (
    .clock_50_mhz           (clk),
    .reset_n                (reset_n),
    .start                  (start),
    .abort                  (abort),
    .cfg_num_windows        (cfg_num_windows),
    .cfg_integration_time   (cfg_integration_time),
    .cfg_modulation_period  (cfg_modulation_period),
    .cfg_settle_cycles      (cfg_settle_cycles),
    .core_integration_time  (core_integration_time),
    .core_modulation_period (core_modulation_period),
    .core_light_en          (core_light_en),
    .core_count_en          (core_count_en),
    .core_clear             (core_clear),
    .core_window_done       (core_window_done),
    .core_add_count         (core_add_count),
    .core_sub_count         (core_sub_count),
    .res_valid              (res_valid),
    .res_ready              (res_ready),
    .res_data               (res_data),
    .res_index              (res_index),
    .res_last               (res_last),
    .busy                   (busy),
    .done                   (done),
    .aborted                (aborted),
    .total_count            (total_count),
    .total_sat              (total_sat)
  );

  fluor_sat_accum #(.TOT_W(48)) u_acc (
    .clk     (clk),
    .resetn  (reset_n),
    .clear   (acc_clear),
    .add_en  (acc_add_en),
    .add_val (acc_val),
    .total   (acc_total),
    .sat     (acc_sat)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ready driver: 0 = always ready, 1 = random, 2 = stall window 1 for 20 clocks
  initial begin
    res_ready = 1'b0;
    forever begin
      tick();
      case (rdy_mode)
        0: res_ready = 1'b1;
        1: res_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (res_valid && res_index == 16'd1 && hold_cnt < 20) begin
            res_ready = 1'b0;
            hold_cnt++;
          end else begin
            res_ready = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_prev = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (aborted) abort_cnt++;
        if (res_valid) begin
          check("report_core_idle", {core_count_en, core_clear}, 2'b00);
          if (hold_prev) begin
            check("hold_data", res_data, prev_data);
            check("hold_index", res_index, prev_idx);
            check("hold_last", res_last, prev_last);
          end
          if (res_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_result", 1, 0);
            end else begin
              mon_e = exp_q.pop_front();
              check("res_data", res_data, mon_e.data);
              check("res_index", res_index, mon_e.idx);
              check("res_last", res_last, mon_e.last);
            end
            hold_prev = 1'b0;
          end else begin
            stall_cnt++;
            hold_prev = 1'b1;
            prev_data = res_data;
            prev_idx  = res_index;
            prev_last = res_last;
          end
        end else begin
          hold_prev = 1'b0;
        end
      end
    end
  end

  task automatic do_run(input int n, input logic [31:0] t, input logic [31:0] p, input logic [15:0] s,
                        input int abort_win, input bit restart, input bit dir);
    logic [48:0] tot;
    logic [31:0] a, b, net;
    int          wait_cnt, d0, ab0;
    bit          cut;
    tot = '0;
    cut = 1'b0;
    d0  = done_cnt;
    ab0 = abort_cnt;
    cfg_num_windows       = 16'(n);
    cfg_integration_time  = t;
    cfg_modulation_period = p;
    cfg_settle_cycles     = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("prog_int_time", core_integration_time, (t < 32'd2) ? 32'd2 : t);
    check("prog_mod_period", core_modulation_period, (p < 32'd2) ? 32'd2 : p);
    check("busy_after_start", busy, n != 0);
    check("total_cleared", total_count, 0);
    if (n == 0) begin
      check("done_zero_win", done, 1);
      check("no_result_zero_win", res_valid, 0);
      tick();
      check("done_one_pulse", done, 0);
    end
    for (int w = 0; w < n; w++) begin
      wait_cnt = 0;
      while (!core_count_en && wait_cnt < 2000) begin
        tick();
        wait_cnt++;
      end
      if (!core_count_en) begin
        check("wait_count_en", 0, 1);
        cut = 1'b1;
        break;
      end
      if (restart && w == 1) begin
        cfg_num_windows = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      repeat ($urandom_range(0, 3)) tick();
      if (dir) begin
        a = dir_add[w];
        b = dir_sub[w];
      end else begin
        a = $urandom;
        b = ($urandom_range(0, 1) == 1) ? $urandom : a - $urandom_range(0, 100);
      end
      net = (a >= b) ? a - b : 32'd0;
      core_add_count   = a;
      core_sub_count   = b;
      core_window_done = 1'b1;
      if (w == abort_win) begin
        abort = 1'b1;
      end else begin
        exp_q.push_back('{net, 16'(w), (w == n - 1)});
        tot += {17'd0, net};
      end
      tick();
      core_window_done = 1'b0;
      abort = 1'b0;
      if (w == abort_win) begin
        check("abort_res_valid", res_valid, 0);
        check("abort_pulse", aborted, 1);
        check("abort_busy", busy, 0);
        check("abort_enables", {core_light_en, core_count_en}, 2'b00);
        cut = 1'b1;
        break;
      end
      check("res_valid_latency", res_valid, 1);
    end
    wait_cnt = 0;
    while (busy && wait_cnt < 5000) begin
      tick();
      wait_cnt++;
    end
    check("run_ends", busy, 0);
    tick();
    check("done_count", done_cnt - d0, cut ? 0 : 1);
    check("abort_count", abort_cnt - ab0, (abort_win >= 0 && abort_win < n) ? 1 : 0);
    check("total", total_count, (tot > 49'h0_FFFF_FFFF_FFFF) ? 48'hFFFF_FFFF_FFFF : tot[47:0]);
    check("total_sat", total_sat, tot > 49'h0_FFFF_FFFF_FFFF);
    check("scoreboard_drained", exp_q.size(), 0);
    check("light_off", core_light_en, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, s0, a0;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    core_window_done = 1'b0;
    core_add_count = '0;
    core_sub_count = '0;
    cfg_num_windows = '0;
    cfg_integration_time = '0;
    cfg_modulation_period = '0;
    cfg_settle_cycles = '0;
    acc_clear = 1'b0;
    acc_add_en = 1'b0;
    acc_val = '0;
    repeat (3) tick();
    check("rst_core_int", core_integration_time, 2);
    check("rst_core_mod", core_modulation_period, 2);
    check("rst_flags", {res_valid, busy, done, aborted, core_light_en, core_count_en, core_clear, total_sat, res_last}, 0);
    check("rst_data", {res_data, res_index}, 0);
    check("rst_total", total_count, 0);
    reset_n = 1'b1;
    tick();

    rdy_mode = 0;
    do_run(3, 32'd100, 32'd10, 16'd5, -1, 1'b0, 1'b1);
    check("directed_total", total_count, 37);

    rdy_mode = 2;
    hold_cnt = 0;
    s0 = stall_cnt;
    do_run(3, 32'd50, 32'd4, 16'd2, -1, 1'b0, 1'b0);
    check("stall_cycles", stall_cnt - s0, 20);

    rdy_mode = 0;
    do_run(0, 32'd0, 32'd1, 16'd0, -1, 1'b0, 1'b0);
    do_run(3, 32'd100, 32'd10, 16'd5, 1, 1'b0, 1'b1);
    check("abort_total", total_count, 30);
    do_run(3, 32'd20, 32'd3, 16'd1, -1, 1'b1, 1'b0);

    cfg_num_windows = 16'd4;
    cfg_integration_time = 32'd77;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    a0 = abort_cnt;
    reset_n = 1'b0;
    tick();
    check("midrst_state", {busy, core_light_en, core_count_en}, 0);
    check("midrst_int", core_integration_time, 2);
    reset_n = 1'b1;
    repeat (2) tick();
    check("midrst_no_abort", abort_cnt - a0, 0);

    rdy_mode = 1;
    for (int r = 0; r < 10; r++) begin
      int n, ab;
      n  = int'($urandom_range(1, 6));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      do_run(n, $urandom_range(0, 300), $urandom_range(0, 40), 16'($urandom_range(0, 8)), ab, 1'b0, 1'b0);
    end

    rdy_mode = 0;
    cfg_num_windows = 16'd1;
    cfg_integration_time = 32'd100;
    cfg_settle_cycles = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!core_count_en && c < 100) begin
      tick();
      c++;
    end
`ifdef FLUOR_SEQ_TIMEOUT_EN
    c = 0;
    while (!aborted && c < 3000) begin
      tick();
      c++;
    end
    check("timeout_cycles", c, 1124);
    check("timeout_busy", busy, 0);
`else
    repeat (1200) tick();
    check("no_watchdog_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("manual_abort", {aborted, busy}, 2'b10);
`endif
    tick();

    acc_clear = 1'b1;
    tick();
    acc_clear = 1'b0;
    acc_add_en = 1'b1;
    acc_val = 48'hFFFF_FFFF_FFF6;
    tick();
    check("acc_preload", {acc_sat, acc_total}, {1'b0, 48'hFFFF_FFFF_FFF6});
    acc_val = 48'h0000_FFFF_FFFF;
    tick();
    check("acc_saturate", {acc_sat, acc_total}, {1'b1, 48'hFFFF_FFFF_FFFF});
    acc_val = 48'd5;
    tick();
    check("acc_hold_sat", {acc_sat, acc_total}, {1'b1, 48'hFFFF_FFFF_FFFF});
    acc_add_en = 1'b0;
    acc_clear = 1'b1;
    tick();
    acc_clear = 1'b0;
    check("acc_clear", {acc_sat, acc_total}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
